// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution frame sequencer.
package conv_pkg;

    localparam int PIX_W    = 3;
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    // True on the outermost row/column of the frame.
    function automatic logic is_border(input logic [HCOUNT_W-1:0] h,
                                       input logic [VCOUNT_W-1:0] v,
                                       input logic [HCOUNT_W-1:0] h_last,
                                       input logic [VCOUNT_W-1:0] v_last);
        return (h == '0) || (h == h_last) || (v == '0) || (v == v_last);
    endfunction

endpackage

// File: rtl/conv_delay_pipe.sv
// Fixed-depth shift register with asynchronous active-low clear; aligns
// read-side sideband (valid, hcount, vcount) with returning BRAM data.
module conv_delay_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 22
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: every stage is cleared so no stale valid can emerge after a mid-frame reset.
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Streams one raster frame from the frame-buffer BRAM into the convolution filter.
// Optional build macro CONV_SEQ_BORDER_ZERO_EN zero-pads the outer pixel ring.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int RD_LATENCY   = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_W       = 17
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    input  logic                abort_in,
    input  logic                pause_in,
    output logic                busy_out,
    output logic                done_out,
    output logic [ADDR_W-1:0]   rd_addr_out,
    output logic                rd_en_out,
    input  logic [PIX_W-1:0]    rd_data_in,
    output logic [PIX_W-1:0]    pixel_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                data_valid_out
);

    localparam int                  DRAIN_CYCLES = RD_LATENCY + FLUSH_CYCLES;
    localparam int                  DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam int                  PIPE_W       = 1 + HCOUNT_W + VCOUNT_W;
    localparam logic [ADDR_W-1:0]   LAST_ADDR    = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST   = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [HCOUNT_W-1:0] H_LAST       = HCOUNT_W'(H_ACTIVE - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST       = VCOUNT_W'(V_ACTIVE - 1);

    seq_state_t          state_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [HCOUNT_W-1:0] h_q, h_d, issue_h_q;
    logic [VCOUNT_W-1:0] v_q, v_d, issue_v_q;
    logic [DRAIN_W-1:0]  drain_q;
    logic                rd_en_q, busy_q, done_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [PIX_W-1:0]    pixel_q;
    logic [PIPE_W-1:0]   pipe_out;

    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        addr_d = addr_q + 1'b1;
        h_d    = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d    = (h_q == H_LAST) ? v_q + 1'b1 : v_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            h_q       <= '0;
            v_q       <= '0;
            issue_h_q <= '0;
            issue_v_q <= '0;
            drain_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make rd_en and done single-cycle unless re-asserted below.
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start_in) begin
                    state_q   <= S_STREAM;
                    addr_q    <= '0;
                    h_q       <= '0;
                    v_q       <= '0;
                    rd_addr_q <= '0;
                    busy_q    <= 1'b1;
                end
                S_STREAM: if (abort_in) begin
                    // Abort outranks issuing, including on the final address.
                    state_q <= S_DRAIN;
                    drain_q <= '0;
                end else if (!pause_in) begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= addr_q;
                    issue_h_q <= h_q;
                    issue_v_q <= v_q;
                    addr_q    <= addr_d;
                    h_q       <= h_d;
                    v_q       <= v_d;
                    if (addr_q == LAST_ADDR) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                    end
                end
                S_DRAIN: if (abort_in) begin
                    drain_q <= '0;
                end else if (drain_q == DRAIN_LAST) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end else begin
                    drain_q <= drain_q + 1'b1;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // One stage beyond the BRAM latency to match the pixel_q register.
    conv_delay_pipe #(
        .DEPTH (RD_LATENCY + 1),
        .WIDTH (PIPE_W)
    ) u_align (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     ({rd_en_q, issue_h_q, issue_v_q}),
        .q_out    (pipe_out)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) pixel_q <= '0;
        else           pixel_q <= rd_data_in;
    end

    assign {data_valid_out, hcount_out, vcount_out} = pipe_out;
    assign rd_en_out   = rd_en_q;
    assign rd_addr_out = rd_addr_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;

`ifdef CONV_SEQ_BORDER_ZERO_EN
    assign pixel_out = is_border(hcount_out, vcount_out, H_LAST, V_LAST) ? '0 : pixel_q;
`else
    assign pixel_out = pixel_q;
`endif

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Sequences one frame of 3-bit pixels from the frame-buffer BRAM into the convolution filter stage.
- Generates raster read addresses and aligned hcount/vcount/valid to the filter, honours a downstream pause, and waits for the filter pipeline to drain before reporting done.
- Sits between the frame-buffer read port and the convolution filter; started by the top-level frame controller.

Parameters:
- H_ACTIVE, 320, pixels per line.
- V_ACTIVE, 240, lines per frame.
- RD_LATENCY, 2, BRAM read latency in cycles (address to data), must be >= 1.
- FLUSH_CYCLES, 2, filter pipeline depth to drain after the last pixel.
- ADDR_W, 17, BRAM address width; must hold H_ACTIVE*V_ACTIVE-1.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  one-cycle frame start request, accepted only in IDLE.
- abort_in  input  1  cancel the current frame.
- pause_in  input  1  downstream hold; no new addresses are issued while high.
- busy_out  output  1  high from the accepted start until done.
- done_out  output  1  one-cycle pulse at the end of a frame (completed or aborted).
- rd_addr_out  output  ADDR_W  BRAM read address.
- rd_en_out  output  1  BRAM read enable.
- rd_data_in  input  3  BRAM read data, valid RD_LATENCY cycles after rd_en_out.
- pixel_out  output  3  pixel to the filter data input.
- hcount_out  output  11  column of pixel_out.
- vcount_out  output  10  row of pixel_out.
- data_valid_out  output  1  pixel_out/hcount_out/vcount_out valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, counters 0, the delay pipe is cleared.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE to STREAM on start_in. The address counter and h/v counters are cleared in the same cycle.
  - STREAM: each cycle with pause_in low issues rd_en_out=1 at the current address, then advances.
    - hcount wraps at H_ACTIVE-1 to 0 and increments vcount.
    - The address increments by 1 (linear counter, no multiplier).
    - With pause_in high, rd_en_out=0 and the counters hold. In-flight reads still complete.
  - STREAM to DRAIN in the cycle after issuing address H_ACTIVE*V_ACTIVE-1.
  - DRAIN waits RD_LATENCY+FLUSH_CYCLES cycles (counter), then moves to DONE. pause_in is ignored in DRAIN.
  - DONE: done_out=1 for exactly one cycle, busy_out drops in that cycle, then returns to IDLE.
- Alignment: rd_en, hcount and vcount pass through a RD_LATENCY-deep shift pipe.
  - data_valid_out, hcount_out and vcount_out are the pipe outputs.
  - pixel_out = rd_data_in registered once; the pipe includes one extra stage to match.
  - Total latency from rd_en_out to data_valid_out is RD_LATENCY+1 cycles.
- busy_out is high in STREAM and DRAIN.
- start_in is ignored outside IDLE; there is no queueing.
- abort_in in STREAM or DRAIN moves to DRAIN with a count of RD_LATENCY+FLUSH_CYCLES. Issuing stops immediately, and in-flight valids still emerge. It then goes to DONE and pulses done_out. abort_in in IDLE or DONE has no effect.
- Simultaneous abort_in and last address: abort wins, and the last read is not issued.
- Asynchronous reset mid-frame returns to IDLE at once without a done pulse. The valid pipe clears, so there are no stray valids.
- Exactly H_ACTIVE*V_ACTIVE valids are emitted per completed frame, in raster order, with no duplicates under pause.

Optional Feature:
- Macro: CONV_SEQ_BORDER_ZERO_EN.
- Defined: pixel_out is forced to 0 when hcount is 0 or H_ACTIVE-1, or vcount is 0 or V_ACTIVE-1. data_valid_out is unchanged, which gives a zero-padded border to the filter.
- Undefined: pixel_out always equals the delayed rd_data_in.

Decomposition:
- Shared package conv_pkg holds the FSM state enum (seq_state_t), the pixel width constant PIX_W=3, HCOUNT_W=11 and VCOUNT_W=10.
- One sub-module, conv_delay_pipe: a parameterised-depth, parameterised-width shift register with async active-low clear. It carries {valid, hcount, vcount}.

Test Plan:
- H=4,V=3,RD_LATENCY=2, BRAM model holding addr[2:0]; pulse start -> rd_en high 12 consecutive cycles, addrs 0..11; 12 valids starting 3 cycles after the first rd_en; (h,v) sequence (0,0)..(3,0),(0,1)..(3,2); done_out 1 cycle, 4 cycles after the last rd_en.
- Same config, pause_in high for 3 cycles after addr 5 -> rd_en low 3 cycles, addr holds at 6, valid gap of 3 cycles, still 12 valids total with no repeats.
- Abort after addr 4 issued -> no further rd_en; exactly 5 valids emerge; done_out pulses; busy_out low afterwards.
- start_in pulsed during STREAM -> ignored; a single done; next start in IDLE runs a full second frame starting at addr 0.
- rst_n_in low for 1 cycle mid-STREAM -> all outputs 0 immediately; no done_out; no valid until the next start.
- With CONV_SEQ_BORDER_ZERO_EN and all-7 BRAM data -> pixel_out=7 only at (1,1),(2,1); all 10 border pixels are 0 and all 12 valids are asserted.
